proc_core_param: RTL and testbench
==================================

Name: proc_core_param

Overview:
- Parametrised successor of the 8-bit three-block processor top (register bank, ALU, control unit).
- Integrates a DATA_W-wide multi-port register bank, an ALU with status flags and a multi-cycle control FSM into one block.
- Fetches 3-address instructions over a valid/ready instruction bus.
- Adds what the first generation lacks: program counter, conditional branch, immediate load, halt.

Parameters:
- DATA_W, 8, register/ALU data width (4..32)
- ADDR_W, 3, register address width; NREGS = 2**ADDR_W
- PC_W, 8, program counter width
- INSTR_W: localparam 4 + 3*ADDR_W, not overridable

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous reset, active-high
- instr_req  out  1  fetch request
- instr_addr  out  PC_W  fetch address (= pc)
- instr_valid  in  1  instruction present on instr_data
- instr_data  in  INSTR_W  {opcode[3:0], dest, src1, src2}
- pc  out  PC_W  current program counter
- status  out  3  {N, C, Z} flags
- halted  out  1  core stopped
- dbg_addr  in  ADDR_W  register read-back address
- dbg_data  out  DATA_W  combinational read of regs[dbg_addr]

Behaviour:
- Reset (synchronous, active-high):
  - pc=0, status=0, halted=0, instr_req=0.
  - All registers 0; state=FETCH.
  - rst wins over every other event, including mid-instruction; no partial writeback survives.
- FSM states and transitions:
  - FETCH: instr_req=1, instr_addr=pc; hold until instr_valid=1, then latch instr_data into IR.
    - Exactly one instruction is captured per handshake; instr_valid outside FETCH is ignored.
    - Goes to DECODE.
  - DECODE: read regs[src1], regs[src2] into operand latches A, B; goes to EXEC.
  - EXEC: compute result R and next flags; goes to WB.
  - WB: write R to regs[dest] if the opcode writes.
    - Update pc: pc+1, or the branch target.
    - Goes to FETCH, or HALT for opcode F.
  - HALT: halted=1, instr_req=0; the only exit is rst.
- Latency: 4 cycles per instruction with instr_valid already high in FETCH; +1 per wait cycle.
- Opcodes (w = writes dest, f = updates flags):
  - 0 NOP
  - 1 ADD (w,f)
  - 2 SUB A-B (w,f)
  - 3 AND (w,f)
  - 4 OR (w,f)
  - 5 XOR (w,f)
  - 6 NAND (w,f)
  - 7 SHL A by 1 (w,f; C = bit shifted out)
  - 8 SHR logical (w,f; C = A[0])
  - 9 MOV A (w)
  - A LDI imm (w): imm = {src1,src2} zero-extended or truncated to DATA_W
  - B BZ: pc = {src1,src2} resized to PC_W if Z=1, else pc+1
  - C MUL (optional feature)
  - D, E: NOP
  - F HALT
- Arithmetic/width rules:
  - ADD: C = carry out of DATA_W.
  - SUB: C = borrow (1 when A < B unsigned).
  - Logical ops: C=0.
  - Z = (R==0); N = R[DATA_W-1].
  - Flags are updated in WB, only for f-opcodes; other opcodes leave flags unchanged.
- Boundary conditions:
  - pc wraps from 2**PC_W-1 to 0.
  - dest == src: read happens in DECODE, before the write, so it is hazard-free.
  - Register 0 is an ordinary register (not hardwired zero).
  - BZ tests flags as they were before the BZ itself.

Optional Feature:
- PROC_MUL_EN defined: opcode C = MUL (w,f).
  - R = low DATA_W bits of A*B.
  - C = 1 if the high half is non-zero.
  - Computed combinationally in EXEC; no extra cycles.
- PROC_MUL_EN undefined: opcode C behaves as NOP; no multiplier logic.

Decomposition:
- Package proc_pkg holds:
  - opcode enum (OP_NOP..OP_HALT)
  - FSM state enum (S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT)
  - flag bit indices FLAG_Z=0, FLAG_C=1, FLAG_N=2
- One natural sub-module, proc_alu: purely combinational, DATA_W parameter, inputs op/A/B, outputs R and flags.
- Register bank and FSM stay in proc_core_param.

Test Plan:
- Reset then LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT, instr_valid always 1:
  - dbg r3 = 8, status = 000, halted after 16 cycles.
- LDI r1,0xFF; LDI r2,1; ADD r3,r1,r2 (DATA_W=8):
  - r3 = 0x00, Z=1, C=1, N=0.
- SUB r3,r1,r2 with r1=2, r2=3: r3 = 0xFF, N=1, C=1, Z=0.
- BZ 0x10 immediately after a result of 0: next instr_addr = 0x10. Same BZ after a non-zero result: instr_addr = pc+1.
- Hold instr_valid low for 5 cycles in FETCH: instr_req and instr_addr stay stable, pc unchanged. Then assert instr_valid for 1 cycle: exactly one instruction executes.
- Assert rst during EXEC of ADD r4 (r4 previously 7): next cycle r4 = 0, pc = 0, state FETCH, instr_req = 1. With PROC_MUL_EN: MUL 0x10*0x10 gives 0x00 with C=1, Z=1.

Source files
------------

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcode/state types, flag indices and opcode attributes
// Optional feature macro: PROC_MUL_EN (opcode C becomes MUL when defined).
package proc_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_NAND = 4'h6,
    OP_SHL  = 4'h7,
    OP_SHR  = 4'h8,
    OP_MOV  = 4'h9,
    OP_LDI  = 4'hA,
    OP_BZ   = 4'hB,
    OP_MUL  = 4'hC,
    OP_NOPD = 4'hD,
    OP_NOPE = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

  // Opcodes that write their result to regs[dest].
  function automatic logic op_writes(input opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NAND,
      OP_SHL, OP_SHR, OP_MOV, OP_LDI: return 1'b1;
`ifdef PROC_MUL_EN
      OP_MUL: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Opcodes that update the {N, C, Z} status flags.
  function automatic logic op_sets_flags(input opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NAND,
      OP_SHL, OP_SHR: return 1'b1;
`ifdef PROC_MUL_EN
      OP_MUL: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/proc_alu.sv
// rtl/proc_alu.sv - combinational ALU producing result and {N, C, Z} flags
// Ports: op (opcode), a/b (operands; b carries the immediate for LDI), r (result), flags.
// Optional feature macro: PROC_MUL_EN adds the low-half multiplier for opcode C.
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] r,
  output logic [2:0]        flags
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic            c;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Top bit of the widened difference is the borrow (set when a < b unsigned).
  assign diff = {1'b0, a} - {1'b0, b};

`ifdef PROC_MUL_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif

  always_comb begin
    r = '0;
    c = 1'b0;
    case (opcode_t'(op))
      OP_ADD:  begin r = sum[DATA_W-1:0];  c = sum[DATA_W];  end
      OP_SUB:  begin r = diff[DATA_W-1:0]; c = diff[DATA_W]; end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_SHL:  begin r = {a[DATA_W-2:0], 1'b0}; c = a[DATA_W-1]; end
      OP_SHR:  begin r = {1'b0, a[DATA_W-1:1]}; c = a[0];        end
      OP_MOV:  r = a;
      OP_LDI:  r = b;
`ifdef PROC_MUL_EN
      OP_MUL:  begin r = prod[DATA_W-1:0]; c = |prod[2*DATA_W-1:DATA_W]; end
`endif
      default: begin r = '0; c = 1'b0; end
    endcase
  end

  assign flags[FLAG_Z] = (r == '0);
  assign flags[FLAG_C] = c;
  assign flags[FLAG_N] = r[DATA_W-1];

endmodule

// File: rtl/proc_core_param.sv
// rtl/proc_core_param.sv - parametrised multi-cycle core: register bank, ALU, control FSM
// Ports: clk/rst (sync active-high), instr_req/instr_addr/instr_valid/instr_data (fetch bus),
//        pc, status {N,C,Z}, halted, dbg_addr/dbg_data (combinational register read-back).
// Optional feature macro: PROC_MUL_EN (opcode C = MUL; otherwise NOP).
module proc_core_param
  import proc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int PC_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  instr_req,
  output logic [PC_W-1:0]       instr_addr,
  input  logic                  instr_valid,
  input  logic [4+3*ADDR_W-1:0] instr_data,
  output logic [PC_W-1:0]       pc,
  output logic [2:0]            status,
  output logic                  halted,
  input  logic [ADDR_W-1:0]     dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);

  localparam int INSTR_W = 4 + 3 * ADDR_W;
  localparam int NREGS   = 2 ** ADDR_W;

  state_t              state;
  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   regs [NREGS];
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [DATA_W-1:0]   res;
  logic [2:0]          res_flags;
  logic [DATA_W-1:0]   alu_r;
  logic [2:0]          alu_flags;

  opcode_t             op;
  logic [ADDR_W-1:0]   dest;
  logic [ADDR_W-1:0]   src1;
  logic [ADDR_W-1:0]   src2;
  logic [2*ADDR_W-1:0] imm;

  assign op   = opcode_t'(ir[INSTR_W-1 -: 4]);
  assign dest = ir[3*ADDR_W-1 -: ADDR_W];
  assign src1 = ir[2*ADDR_W-1 -: ADDR_W];
  assign src2 = ir[ADDR_W-1:0];
  assign imm  = {src1, src2};

  assign instr_addr = pc;
  assign dbg_data   = regs[dbg_addr];

  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .op    (ir[INSTR_W-1 -: 4]),
    .a     (op_a),
    .b     (op_b),
    .r     (alu_r),
    .flags (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= '0;
      status    <= '0;
      halted    <= 1'b0;
      instr_req <= 1'b0;
      ir        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      res       <= '0;
      res_flags <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          // The request is raised one cycle into FETCH after reset, so a
          // handshake only counts once instr_req is actually visible.
          if (instr_req && instr_valid) begin
            ir        <= instr_data;
            instr_req <= 1'b0;
            state     <= S_DECODE;
          end else begin
            instr_req <= 1'b1;
          end
        end
        S_DECODE: begin
          // Operands are latched here, before any writeback, so dest == src is safe.
          op_a  <= regs[src1];
          op_b  <= (op == OP_LDI) ? DATA_W'(imm) : regs[src2];
          state <= S_EXEC;
        end
        S_EXEC: begin
          res       <= alu_r;
          res_flags <= alu_flags;
          state     <= S_WB;
        end
        S_WB: begin
          if (op_writes(op)) regs[dest] <= res;
          if (op_sets_flags(op)) status <= res_flags;
          // BZ sees status as left by the previous instruction; BZ never sets flags.
          if (op == OP_BZ && status[FLAG_Z]) pc <= PC_W'(imm);
          else                               pc <= pc + PC_W'(1);
          if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            instr_req <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_HALT: begin
          halted    <= 1'b1;
          instr_req <= 1'b0;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_core_param.sv
// tb/tb_proc_core_param.sv - directed self-checking bench for proc_core_param
module tb_proc_core_param;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 3;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 4 + 3 * ADDR_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               instr_req;
  logic [PC_W-1:0]    instr_addr;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_data;
  logic [PC_W-1:0]    pc;
  logic [2:0]         status;
  logic               halted;
  logic [ADDR_W-1:0]  dbg_addr;
  logic [DATA_W-1:0]  dbg_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0;
  logic [PC_W-1:0] pc0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  proc_core_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .pc          (pc),
    .status      (status),
    .halted      (halted),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, {24'd0, dbg_data}, {24'd0, exp});
  endtask

  function automatic logic [INSTR_W-1:0] enc(input logic [3:0] op, input logic [2:0] d,
                                             input logic [2:0] s1, input logic [2:0] s2);
    return {op, d, s1, s2};
  endfunction

  function automatic logic [INSTR_W-1:0] ldi(input logic [2:0] d, input logic [5:0] imm);
    return {4'hA, d, imm};
  endfunction

  // Present one instruction, wait for it to be taken and for its writeback to finish.
  task automatic issue(input logic [INSTR_W-1:0] ins, input logic keep_valid);
    int n;
    n = 0;
    instr_data  = ins;
    instr_valid = 1'b1;
    while (!instr_req && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!instr_req) begin
      chk("fetch_timeout", {31'd0, instr_req}, 32'd1);
    end else begin
      @(posedge clk); #1;
      if (!keep_valid) instr_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    instr_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr_data = '0;
    dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_status", {29'd0, status}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_req", {31'd0, instr_req}, 32'd0);
    chk_reg("rst_r0", 3'd0, 8'h00);
    rst = 1'b0;

    // Program 1 with instr_valid held high throughout.
    @(posedge clk); #1;
    t0 = cyc;
    chk("p1_req", {31'd0, instr_req}, 32'd1);
    issue(ldi(3'd1, 6'd5), 1'b1);
    issue(ldi(3'd2, 6'd3), 1'b1);
    issue(enc(4'h1, 3'd3, 3'd1, 3'd2), 1'b1);
    issue(enc(4'hF, 3'd0, 3'd0, 3'd0), 1'b1);
    chk("p1_cycles", cyc - t0, 32'd16);
    chk("p1_halted", {31'd0, halted}, 32'd1);
    chk("p1_req_off", {31'd0, instr_req}, 32'd0);
    chk("p1_pc", {24'd0, pc}, 32'd4);
    chk("p1_status", {29'd0, status}, 32'b000);
    chk_reg("p1_r3", 3'd3, 8'd8);
    repeat (5) @(posedge clk);
    #1;
    chk("p1_halt_hold", {31'd0, halted}, 32'd1);
    chk("p1_pc_hold", {24'd0, pc}, 32'd4);

    // Program 2: flags, branch, hazards.
    do_reset();
    issue(enc(4'h6, 3'd1, 3'd0, 3'd0), 1'b0);
    chk_reg("nand_r1", 3'd1, 8'hFF);
    chk("nand_status", {29'd0, status}, 32'b100);
    issue(ldi(3'd2, 6'd1), 1'b0);
    issue(enc(4'h1, 3'd3, 3'd1, 3'd2), 1'b0);
    chk_reg("addc_r3", 3'd3, 8'h00);
    chk("addc_status", {29'd0, status}, 32'b011);
    issue(enc(4'hB, 3'd0, 3'd2, 3'd0), 1'b0);
    chk("bz_taken_pc", {24'd0, pc}, 32'h10);
    chk("bz_taken_addr", {24'd0, instr_addr}, 32'h10);
    issue(ldi(3'd1, 6'd2), 1'b0);
    issue(ldi(3'd2, 6'd3), 1'b0);
    issue(enc(4'h2, 3'd3, 3'd1, 3'd2), 1'b0);
    chk_reg("sub_r3", 3'd3, 8'hFF);
    chk("sub_status", {29'd0, status}, 32'b110);
    issue(enc(4'hB, 3'd0, 3'd2, 3'd0), 1'b0);
    chk("bz_not_taken_pc", {24'd0, pc}, 32'h14);
    chk("bz_keeps_status", {29'd0, status}, 32'b110);
    issue(enc(4'h1, 3'd1, 3'd1, 3'd1), 1'b0);
    chk_reg("hazard_r1", 3'd1, 8'd4);
    issue(ldi(3'd0, 6'd9), 1'b0);
    chk_reg("r0_ordinary", 3'd0, 8'd9);
    issue(enc(4'h7, 3'd4, 3'd3, 3'd0), 1'b0);
    chk_reg("shl_r4", 3'd4, 8'hFE);
    chk("shl_status", {29'd0, status}, 32'b110);
    issue(enc(4'h8, 3'd5, 3'd1, 3'd0), 1'b0);
    chk_reg("shr_r5", 3'd5, 8'h02);
    chk("shr_status", {29'd0, status}, 32'b000);
    issue(ldi(3'd1, 6'h10), 1'b0);
    issue(ldi(3'd2, 6'h10), 1'b0);
    issue(enc(4'hC, 3'd3, 3'd1, 3'd2), 1'b0);
`ifdef PROC_MUL_EN
    chk_reg("mul_r3", 3'd3, 8'h00);
    chk("mul_status", {29'd0, status}, 32'b011);
`else
    chk_reg("opc_nop_r3", 3'd3, 8'hFF);
    chk("opc_nop_status", {29'd0, status}, 32'b000);
`endif

    // Fetch stall, then a single-cycle valid pulse.
    pc0 = pc;
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_req", {31'd0, instr_req}, 32'd1);
      chk("stall_addr", {24'd0, instr_addr}, {24'd0, pc0});
    end
    instr_data = ldi(3'd5, 6'd7);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reg("pulse_r5", 3'd5, 8'd7);
    chk("pulse_pc", {24'd0, pc}, {24'd0, pc0 + 8'd1});
    repeat (8) @(posedge clk);
    #1;
    chk("pulse_once_pc", {24'd0, pc}, {24'd0, pc0 + 8'd1});
    chk("pulse_req", {31'd0, instr_req}, 32'd1);

    // Reset while ADD r4 is in EXEC.
    issue(ldi(3'd4, 6'd7), 1'b0);
    chk_reg("pre_rst_r4", 3'd4, 8'd7);
    instr_data = enc(4'h1, 3'd4, 3'd4, 3'd4);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reg("midrst_r4", 3'd4, 8'd0);
    chk("midrst_pc", {24'd0, pc}, 32'd0);
    chk("midrst_status", {29'd0, status}, 32'd0);
    chk("midrst_req", {31'd0, instr_req}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst_req", {31'd0, instr_req}, 32'd1);
    chk("postrst_addr", {24'd0, instr_addr}, 32'd0);

    // Program counter wrap.
    for (int i = 0; i < 255; i++) issue(enc(4'h0, 3'd0, 3'd0, 3'd0), 1'b0);
    chk("pc_max", {24'd0, pc}, 32'd255);
    issue(enc(4'h0, 3'd0, 3'd0, 3'd0), 1'b0);
    chk("pc_wrap", {24'd0, pc}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
